instr_fetch_unit: RTL and testbench

//  Fetch stage directly upstream of the main decoder: owns the PC, fetches instruction

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM encoding, reset PC default,
// and the buffered fetch entry (instruction word plus its PC+4).
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count and a clear that overrides push/pop.
// Push while full is accepted only together with a pop.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop, full;

    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The issue rule upstream must never offer a push into a full buffer without a pop.
    no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i || clear_i)
        !(push_i && !pop_i && full));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding requests to instruction memory,
// buffers returned words for decode and handles execute redirects.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [5:0]  instr_op_o,
    output logic [31:0] pc_plus4_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   redir_q, redir_d;

    logic [CW-1:0] fifo_count, cnt_after_pop;
    logic          pop, push, issue_ok, room_after_push;
    fetch_entry_t  push_entry, head_entry;

    assign instr_valid_o   = (fifo_count != '0);
    assign pop             = instr_valid_o && instr_ready_i;
    // Slot freed by this cycle's pop already counts toward the next issue decision.
    assign cnt_after_pop   = fifo_count - CW'(pop);
    assign issue_ok        = (cnt_after_pop < CW'(FIFO_DEPTH));
    assign room_after_push = (cnt_after_pop < CW'(FIFO_DEPTH - 1));
    assign push            = (state_q == FETCH) && imem_ack_i && !redirect_i;
    assign push_entry      = '{instr: imem_rdata_i, pc_plus4: pc_q + 32'd4};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_d    = redir_q;
        imem_req_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    pc_d    = align_pc(redirect_pc_i);
                    state_d = FETCH;
                end else if (issue_ok) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        pc_d = align_pc(redirect_pc_i);
                    end else begin
                        redir_d = align_pc(redirect_pc_i);
                        state_d = DROP;
                    end
                end else if (imem_ack_i) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = room_after_push ? FETCH : IDLE;
                end
            end
            DROP: begin
                // The stale request keeps its address until memory answers it.
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    redir_d = align_pc(redirect_pc_i);
                end else if (imem_ack_i) begin
                    pc_d    = redir_q;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            redir_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (push_entry),
        .head_o  (head_entry),
        .count_o (fifo_count)
    );

    assign imem_addr_o = pc_q;
    assign instr_o     = instr_valid_o ? head_entry.instr : '0;
    assign pc_plus4_o  = instr_valid_o ? head_entry.pc_plus4 : '0;
    assign instr_op_o  = instr_o[31:26];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed cycle-exact scenarios followed by a randomized
// run checked against a transaction-level model of the fetch stream.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc_plus4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_9E17;
    endfunction

    assign rdata = mem_word(addr);

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (valid),
        .instr_ready_i (ready),
        .instr_o       (instr),
        .instr_op_o    (op),
        .pc_plus4_o    (pc_plus4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
        check({tag, "_valid"}, 32'(valid), 32'd1);
        check({tag, "_instr"}, instr, w);
        check({tag, "_op"}, 32'(op), 32'(w[31:26]));
        check({tag, "_pc4"}, pc_plus4, a + 32'd4);
    endtask

    task automatic do_reset(input string tag);
        rst         = 1'b1;
        ack         = 1'b0;
        ready       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        tick();
        tick();
        check({tag, "_rst_req"}, 32'(req), 32'd0);
        check({tag, "_rst_valid"}, 32'(valid), 32'd0);
        check({tag, "_rst_instr"}, instr, 32'd0);
        check({tag, "_rst_pc4"}, pc_plus4, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] exp_fetch, prev_addr, rp;
        logic        drop, waiting, acc;
        int          pushes, delivered;

        // 1: streaming with ack and ready always high
        do_reset("t1");
        ack = 1'b1; ready = 1'b1;
        tick();
        check("t1_c1_req", 32'(req), 32'd1);
        check("t1_c1_addr", addr, RESET_PC);
        check("t1_c1_valid", 32'(valid), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            check("t1_addr", addr, 32'(4 * (k - 1)));
            check_head("t1_head", 32'(4 * (k - 2)));
        end

        // 2: decode stalled, buffer fills to depth and requests stop
        do_reset("t2");
        ack = 1'b1; ready = 1'b0;
        pushes = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (req && ack) pushes++;
        end
        check("t2_pushes", 32'(pushes), 32'd2);
        check("t2_req_idle", 32'(req), 32'd0);
        check_head("t2_head0", 32'h0);
        ready = 1'b1;
        tick();
        check("t2_resume_req", 32'(req), 32'd1);
        check("t2_resume_addr", addr, 32'h8);
        check_head("t2_head1", 32'h4);

        // 3: redirect while a request waits; stale response must be discarded
        do_reset("t3");
        ack = 1'b0; ready = 1'b1;
        tick();
        check("t3_c1_req", 32'(req), 32'd1);
        check("t3_c1_addr", addr, RESET_PC);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            check("t3_drop_req", 32'(req), 32'd1);
            check("t3_drop_addr", addr, RESET_PC);
            check("t3_drop_valid", 32'(valid), 32'd0);
            tick();
        end
        ack = 1'b1;
        check("t3_c4_addr", addr, RESET_PC);
        tick();
        check("t3_c5_addr", addr, 32'h100);
        check("t3_c5_valid", 32'(valid), 32'd0);
        tick();
        check_head("t3_head", 32'h100);

        // 4: redirect coinciding with ack, unaligned target
        do_reset("t4");
        ack = 1'b1; ready = 1'b0;
        tick();
        tick();
        check("t4_c2_valid", 32'(valid), 32'd1);
        check("t4_c2_addr", addr, 32'h4);
        redirect = 1'b1; redirect_pc = 32'h203;
        tick();
        redirect = 1'b0; ack = 1'b0;
        check("t4_c3_req", 32'(req), 32'd1);
        check("t4_c3_addr", addr, 32'h200);
        check("t4_c3_valid", 32'(valid), 32'd0);
        tick();
        check("t4_c4_valid", 32'(valid), 32'd0);
        check("t4_c4_addr", addr, 32'h200);

        // 5: PC wraps past the top of the address space
        do_reset("t5");
        ack = 1'b1; ready = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        check("t5_c2_addr", addr, 32'hFFFF_FFFC);
        check("t5_c2_valid", 32'(valid), 32'd0);
        tick();
        check("t5_c3_addr", addr, 32'h0);
        check_head("t5_head", 32'hFFFF_FFFC);

        // 6: reset mid-fetch with ack and redirect pending
        do_reset("t6");
        ack = 1'b1; ready = 1'b0;
        tick();
        tick();
        check("t6_c2_valid", 32'(valid), 32'd1);
        check("t6_c2_addr", addr, 32'h4);
        rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        check("t6_c3_req", 32'(req), 32'd0);
        check("t6_c3_valid", 32'(valid), 32'd0);
        check("t6_c3_instr", instr, 32'd0);
        rst = 1'b0; redirect = 1'b0;
        tick();
        check("t6_c4_req", 32'(req), 32'd1);
        check("t6_c4_addr", addr, RESET_PC);
        tick();
        check_head("t6_head", RESET_PC);

        // Randomized run: stream of delivered instructions must follow the redirect targets
        do_reset("rnd");
        q.delete();
        exp_fetch = RESET_PC;
        drop      = 1'b0;
        waiting   = 1'b0;
        prev_addr = '0;
        delivered = 0;
        for (int c = 0; c < 1500; c++) begin
            ack      = ($urandom_range(3) != 0);
            ready    = ($urandom_range(3) != 0);
            redirect = ($urandom_range(15) == 0);
            rp       = $urandom;
            if ($urandom_range(3) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            redirect_pc = rp;
            #4;
            check("rnd_valid", 32'(valid), 32'(q.size() != 0));
            if (q.size() != 0) check_head("rnd_head", q[0]);
            if (waiting) begin
                check("rnd_req_hold", 32'(req), 32'd1);
                check("rnd_addr_hold", addr, prev_addr);
            end
            acc = req && ack;
            if (redirect) begin
                q.delete();
                exp_fetch = {rp[31:2], 2'b00};
                drop      = req && (!ack || drop);
            end else begin
                if (valid && ready && q.size() != 0) begin
                    void'(q.pop_front());
                    delivered++;
                end
                if (acc) begin
                    if (drop) begin
                        drop = 1'b0;
                    end else begin
                        check("rnd_fetch_addr", addr, exp_fetch);
                        q.push_back(exp_fetch);
                        exp_fetch = exp_fetch + 32'd4;
                    end
                end
            end
            waiting   = req && !ack;
            prev_addr = addr;
            tick();
        end
        check("rnd_liveness", 32'(delivered > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
